// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM encoding, default bit
// period and frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } rx_state_t;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit; both stages reset to
// RESET_VAL so an idle-high line never looks like an edge after reset.
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic nRst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register, valid/ready handoff,
// and single-cycle frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_BITS - 1);

    logic                 rs;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 byte_done;
    logic                 stop_bad;

    bit_sync #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk (clk),
        .nRst(nRst),
        .d_i (rx),
        .q_o (rs)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_idx_d = '0;
                if (!rs) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            // Half a bit in, a start bit must still be low; otherwise it was a glitch.
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d             = '0;
                    shift_d[bit_idx_q] = rs;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rs) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = ST_WAIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A broken frame leaves the line low; wait for idle before hunting again.
            ST_WAIT_HI: begin
                if (rs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = stop_bad;
        overrun_d   = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        // A byte landing in the same cycle the consumer drains the register is kept.
        if (byte_done) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a short bit period: sequence, false start,
// framing error, overrun, same-cycle handoff and mid-frame reset.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB    = 16;
    localparam int CLK_NS = 10;
    localparam int BIT_NS = CPB * CLK_NS;

    logic       clk = 1'b0;
    logic       nRst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b1;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail = 0;

    int         rx_count = 0;
    logic [7:0] last_byte = 8'h00;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         valid_drop_cnt = 0;
    bit         watch_valid = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .nRst     (nRst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #(CLK_NS / 2) clk = ~clk;

    always @(negedge clk) begin
        if (nRst) begin
            if (valid && ready) begin
                rx_count  = rx_count + 1;
                last_byte = data;
                $display("[%0t] rx byte %02h accepted (#%0d)", $time, data, rx_count);
            end
            if (frame_err) fe_cnt = fe_cnt + 1;
            if (overrun)   ov_cnt = ov_cnt + 1;
            if (watch_valid && !valid) valid_drop_cnt = valid_drop_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low_bits);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        for (int s = 0; s < STOP_BITS; s++) begin
            rx = stop_bit;
            #(BIT_NS);
        end
        if (!stop_bit) #(extra_low_bits * BIT_NS);
        rx = 1'b1;
    endtask

    initial begin
        int exp_count;
        int fe0;
        int ov0;

        // Asynchronous reset: outputs must clear before any clock edge.
        #2 nRst = 1'b0;
        #1;
        check_eq("rst_data", 32'(data), 32'h00);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_frame_err", 32'(frame_err), 32'h0);
        check_eq("rst_overrun", 32'(overrun), 32'h0);
        check_eq("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        repeat (4) @(negedge clk);
        nRst = 1'b1;
        repeat (4) @(negedge clk);

        // Byte sequence 0xEB..0xFE with ready held high.
        ready = 1'b1;
        exp_count = 0;
        for (int b = 8'hEB; b <= 8'hFE; b++) begin
            @(posedge clk); #3;
            send_frame(8'(b), 1'b1, 0);
            #(BIT_NS);
            exp_count++;
            $display("[%0t] sent %02h", $time, b);
            check_eq("seq_count", 32'(rx_count), 32'(exp_count));
            check_eq("seq_byte", 32'(last_byte), 32'(b));
        end
        check_eq("seq_valid_idle", 32'(valid), 32'h0);
        check_eq("seq_frame_err", 32'(fe_cnt), 32'h0);
        check_eq("seq_overrun", 32'(ov_cnt), 32'h0);

        // False start: line low for a quarter bit only.
        fe0 = fe_cnt;
        @(posedge clk); #3;
        rx = 1'b0;
        #(4 * CLK_NS);
        rx = 1'b1;
        #(3 * BIT_NS);
        $display("[%0t] glitch done", $time);
        check_eq("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
        check_eq("glitch_count", 32'(rx_count), 32'(exp_count));
        check_eq("glitch_valid", 32'(valid), 32'h0);
        check_eq("glitch_frame_err", 32'(fe_cnt - fe0), 32'h0);
        @(posedge clk); #3;
        send_frame(8'h5A, 1'b1, 0);
        #(BIT_NS);
        exp_count++;
        $display("[%0t] sent 5a", $time);
        check_eq("after_glitch_count", 32'(rx_count), 32'(exp_count));
        check_eq("after_glitch_byte", 32'(last_byte), 32'h5A);

        // Bad stop bit followed by a long low line, then a good frame.
        fe0 = fe_cnt;
        @(posedge clk); #3;
        send_frame(8'h55, 1'b0, 20);
        #(2 * BIT_NS);
        $display("[%0t] sent 55 with bad stop", $time);
        check_eq("ferr_pulses", 32'(fe_cnt - fe0), 32'h1);
        check_eq("ferr_no_byte", 32'(rx_count), 32'(exp_count));
        check_eq("ferr_valid", 32'(valid), 32'h0);
        @(posedge clk); #3;
        send_frame(8'hA3, 1'b1, 0);
        #(BIT_NS);
        exp_count++;
        $display("[%0t] sent a3", $time);
        check_eq("after_ferr_count", 32'(rx_count), 32'(exp_count));
        check_eq("after_ferr_byte", 32'(last_byte), 32'hA3);
        check_eq("after_ferr_pulses", 32'(fe_cnt - fe0), 32'h1);

        // Overrun: consumer stalled, second byte dropped.
        ready = 1'b0;
        ov0 = ov_cnt;
        @(posedge clk); #3;
        send_frame(8'hF0, 1'b1, 0);
        #(BIT_NS);
        $display("[%0t] sent f0 (ready low)", $time);
        check_eq("hold_valid", 32'(valid), 32'h1);
        check_eq("hold_data", 32'(data), 32'hF0);
        watch_valid = 1'b1;
        @(posedge clk); #3;
        send_frame(8'h0F, 1'b1, 0);
        #(BIT_NS);
        $display("[%0t] sent 0f (ready low)", $time);
        check_eq("ovr_valid", 32'(valid), 32'h1);
        check_eq("ovr_data", 32'(data), 32'hF0);
        check_eq("ovr_pulses", 32'(ov_cnt - ov0), 32'h1);
        check_eq("ovr_valid_drop", 32'(valid_drop_cnt), 32'h0);

        // Same-cycle handoff: ready high only in the stop-sample cycle of 0x0F.
        ov0 = ov_cnt;
        @(posedge clk); #3;
        fork
            send_frame(8'h0F, 1'b1, 0);
            begin
                repeat (154) @(posedge clk);
                #2 ready = 1'b1;
                @(posedge clk);
                #2 ready = 1'b0;
            end
        join
        #(BIT_NS);
        $display("[%0t] sent 0f with ready pulse", $time);
        check_eq("handoff_data", 32'(data), 32'h0F);
        check_eq("handoff_valid", 32'(valid), 32'h1);
        check_eq("handoff_overrun", 32'(ov_cnt - ov0), 32'h0);
        check_eq("handoff_valid_drop", 32'(valid_drop_cnt), 32'h0);
        watch_valid = 1'b0;

        // Reset during data bit 4 of 0xC3.
        @(posedge clk); #3;
        fork
            send_frame(8'hC3, 1'b1, 0);
            begin
                #(BIT_NS * 5 + BIT_NS / 2);
                nRst = 1'b0;
                #1;
                $display("[%0t] reset mid-frame", $time);
                check_eq("midrst_valid", 32'(valid), 32'h0);
                check_eq("midrst_data", 32'(data), 32'h00);
                check_eq("midrst_frame_err", 32'(frame_err), 32'h0);
                check_eq("midrst_overrun", 32'(overrun), 32'h0);
                check_eq("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
            end
        join
        @(negedge clk);
        nRst = 1'b1;
        ready = 1'b1;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_count = rx_count;
        repeat (4) @(negedge clk);
        check_eq("postrst_valid", 32'(valid), 32'h0);
        @(posedge clk); #3;
        send_frame(8'h3C, 1'b1, 0);
        #(BIT_NS);
        exp_count++;
        $display("[%0t] sent 3c after reset", $time);
        check_eq("postrst_count", 32'(rx_count), 32'(exp_count));
        check_eq("postrst_byte", 32'(last_byte), 32'h3C);
        check_eq("postrst_frame_err", 32'(fe_cnt - fe0), 32'h0);
        check_eq("postrst_overrun", 32'(ov_cnt - ov0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clocks per bit (50 MHz / 115200 baud); legal minimum 4.
REQ-002 clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-003 nRst  input  1  reset, asynchronous, active-low.
REQ-004 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 data  output  8  received byte, valid while valid=1.
REQ-006 valid  output  1  holding register full.
REQ-007 ready  input  1  consumer accepts data when valid&ready.
REQ-008 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-009 overrun  output  1  one-cycle pulse when a good byte is dropped.

Function
REQ-010 Frame SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-011 rx SHALL pass a two-flop synchronizer; both flops reset to 1; all decisions use the synchronized value rs.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HI.
REQ-013 IDLE: rs=0 -> START, bit counter cleared.
REQ-014 START: at count CLKS_PER_BIT/2-1, sample rs; rs=1 -> IDLE (false start, no output); rs=0 -> DATA, counter cleared.
REQ-015 DATA: at count CLKS_PER_BIT-1, sample rs into shift register bit index 0..7, counter cleared; after index 7 -> STOP.
REQ-016 STOP: at count CLKS_PER_BIT-1, sample rs; rs=1 -> byte complete, IDLE; rs=0 -> frame_err pulse, byte discarded, WAIT_HI.
REQ-017 WAIT_HI: remain until rs=1, then IDLE; no start detection while in WAIT_HI.
REQ-018 Counter width SHALL be clog2(CLKS_PER_BIT); counter never wraps past CLKS_PER_BIT-1.
REQ-019 On byte complete with valid=0: data loaded, valid=1 on the following clock edge.
REQ-020 valid SHALL stay 1 and data stable until a cycle with valid&ready; valid then falls next edge.
REQ-021 Byte complete while valid=1 and ready=0: new byte dropped, data unchanged, overrun pulses one cycle.
REQ-022 Byte complete in same cycle as valid&ready: new byte loaded, valid stays 1, no overrun.
REQ-023 frame_err and overrun SHALL never be asserted more than one consecutive cycle per event.
REQ-024 Latency: valid rises 1 cycle after stop-bit sample, i.e. about 9.5 bit times + 3 clocks after the rx falling edge.

Reset
REQ-025 nRst low SHALL immediately force: state IDLE, counters 0, shift register 0, data 8'h00, valid 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-026 Reset mid-frame discards the partial byte; the next full frame after release is received normally.

Structure
REQ-027 Shared package (uart_pkg) SHALL hold the FSM state encoding, default CLKS_PER_BIT and frame constants (data bits = 8, stop bits = 1).
REQ-028 One sub-module, bit_sync (two-flop synchronizer, reset value parameterised), SHALL be instantiated for rx; everything else stays in uart_rx.
REQ-029 RTL size target 120-400 lines; no latches, no combinational path from rx to any output.

Verification
REQ-030 ready=1, send 0xEB at 8700 ns/bit -> single valid with data=0xEB; bytes 0xEB..0xFE in sequence each received exactly once, in order.
REQ-031 rx low for 100 clocks then high -> no valid, no frame_err, FSM back in IDLE; following 0x5A received correctly.
REQ-032 Send 0x55 with stop bit 0, line held low 20 bit times, then 0xA3 -> one frame_err pulse, no valid for 0x55, no spurious byte during low period, 0xA3 received.
REQ-033 ready=0, send 0xF0 then 0x0F -> valid=1 data=0xF0 throughout, one overrun pulse at second stop sample, data still 0xF0.
REQ-034 valid=1 holding 0xF0, ready pulsed exactly in the completion cycle of 0x0F -> data=0x0F, valid never drops, no overrun.
REQ-035 nRst asserted during data bit 4 of 0xC3 -> all outputs reset values within the same cycle; after release, 0x3C received with no error pulses.
